// File: rtl/multi_dataflow_cfg_master_pkg.sv
// multi_dataflow_cfg_master_pkg: register indices, offsets and types shared by the job launcher
package multi_dataflow_cfg_master_pkg;
  localparam logic [7:0] REG_IN_PEL_ADDR = 8'd0;
  localparam logic [7:0] REG_IN_SIZE_ADDR = 8'd1;
  localparam logic [7:0] REG_OUT_PEL_ADDR = 8'd2;
  localparam logic [7:0] REG_NB_ITER = 8'd3;
  localparam logic [7:0] REG_CNT_LIMIT_OUT_PEL = 8'd6;
  localparam logic [7:0] REG_IN_PEL_TRANS_SIZE = 8'd7;
  localparam logic [7:0] REG_IN_SIZE_TRANS_SIZE = 8'd16;
  localparam logic [7:0] REG_OUT_PEL_TRANS_SIZE = 8'd25;
  localparam logic [31:0] CNT_LEN = 32'd1024;
  localparam logic [31:0] CTRL_TRIGGER_OFFS = 32'h00;
  localparam logic [31:0] CTRL_ACQUIRE_OFFS = 32'h04;
  localparam logic [31:0] CTRL_STATUS_OFFS = 32'h0C;
  localparam int unsigned CFG_NB_WRITES = 8;
  typedef struct packed {
    logic [31:0] in_pel_addr;
    logic [31:0] in_size_addr;
    logic [31:0] out_pel_addr;
    logic [31:0] len;
  } job_desc_t;
  typedef enum logic [2:0] {
    CFG_IDLE, CFG_ACQUIRE, CFG_ACQ_WAIT, CFG_WRITE, CFG_TRIGGER, CFG_POLL, CFG_GAP, CFG_DONE
  } cfg_state_t;
endpackage

// File: rtl/multi_dataflow_cfg_master.sv
// multi_dataflow_cfg_master: launches one HWPE job per descriptor over the peripheral port
module multi_dataflow_cfg_master
  import multi_dataflow_cfg_master_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 8,
  parameter logic [31:0] REGFILE_BASE = 32'h40,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  job_desc_t           job_desc_i,
  output logic                done_o,
  output logic                err_o,
  output logic [7:0]          job_id_o,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic                periph_r_valid_i,
  input  logic [31:0]         periph_r_data_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i
);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  cfg_state_t state_q, state_d;
  job_desc_t desc_q, desc_d;
  logic req_q, req_d, pend_q, pend_d, err_q, err_d, acq_q, acq_d, wen_q, wen_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] job_id_q, job_id_d, widx;
  logic [31:0] add_q, add_d, data_q, data_d, wdat;
  logic rsp, unused_ok;
  assign rsp = periph_r_valid_i & ((req_q & periph_gnt_i) | pend_q);
  always_comb begin
    state_d = state_q;
    desc_d = desc_q;
    req_d = req_q;
    pend_d = pend_q;
    err_d = err_q;
    acq_d = acq_q;
    wcnt_d = wcnt_q;
    gap_d = gap_q;
    job_id_d = job_id_q;
    if (req_q && periph_gnt_i) begin
      req_d = 1'b0;
      pend_d = !periph_r_valid_i;
    end
    if (pend_q && periph_r_valid_i) pend_d = 1'b0;
    case (state_q)
      CFG_IDLE: if (job_valid_i) begin
        desc_d = job_desc_i;
        err_d = 1'b0;
        state_d = CFG_ACQUIRE;
      end
      CFG_ACQUIRE: if (!req_q && !pend_q) begin
        err_d = desc_q.len == '0 || desc_q.len > CNT_LEN;
        state_d = err_d ? CFG_DONE : CFG_ACQUIRE;
        req_d = !err_d;
      end else if (rsp) begin
        acq_d = 1'b1;
        gap_d = '0;
        wcnt_d = '0;
        job_id_d = periph_r_data_i[7:0];
        state_d = &periph_r_data_i ? CFG_GAP : CFG_WRITE;
        req_d = !(&periph_r_data_i);
      end
      CFG_WRITE: if (rsp) begin
        wcnt_d = wcnt_q + 3'd1;
        state_d = wcnt_q == 3'(CFG_NB_WRITES - 1) ? CFG_TRIGGER : CFG_WRITE;
        req_d = 1'b1;
      end
      CFG_TRIGGER: if (rsp) begin
        acq_d = 1'b0;
        gap_d = '0;
        state_d = CFG_GAP;
      end
      CFG_POLL: if (rsp) begin
        acq_d = 1'b0;
        gap_d = '0;
        state_d = |periph_r_data_i ? CFG_GAP : CFG_DONE;
      end
      CFG_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(POLL_GAP - 1)) begin
          state_d = acq_q ? CFG_ACQUIRE : CFG_POLL;
          req_d = 1'b1;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end
  always_comb begin
    case (wcnt_d)
      3'd0: begin widx = REG_IN_PEL_ADDR; wdat = desc_q.in_pel_addr; end
      3'd1: begin widx = REG_IN_SIZE_ADDR; wdat = desc_q.in_size_addr; end
      3'd2: begin widx = REG_OUT_PEL_ADDR; wdat = desc_q.out_pel_addr; end
      3'd3: begin widx = REG_NB_ITER; wdat = 32'd1; end
      3'd4: begin widx = REG_CNT_LIMIT_OUT_PEL; wdat = desc_q.len; end
      3'd5: begin widx = REG_IN_PEL_TRANS_SIZE; wdat = desc_q.len; end
      3'd6: begin widx = REG_IN_SIZE_TRANS_SIZE; wdat = desc_q.len; end
      default: begin widx = REG_OUT_PEL_TRANS_SIZE; wdat = desc_q.len; end
    endcase
    add_d = state_d == CFG_ACQUIRE ? CTRL_ACQUIRE_OFFS :
            state_d == CFG_POLL ? CTRL_STATUS_OFFS :
            state_d == CFG_WRITE ? REGFILE_BASE + {22'd0, widx, 2'b00} : CTRL_TRIGGER_OFFS;
    wen_d = state_d == CFG_ACQUIRE || state_d == CFG_POLL;
    data_d = state_d == CFG_WRITE ? wdat : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CFG_IDLE;
      desc_q <= '0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      acq_q <= 1'b0;
      wcnt_q <= '0;
      gap_q <= '0;
      job_id_q <= '0;
      add_q <= '0;
      wen_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      desc_q <= desc_d;
      req_q <= req_d;
      pend_q <= pend_d;
      err_q <= err_d;
      acq_q <= acq_d;
      wcnt_q <= wcnt_d;
      gap_q <= gap_d;
      job_id_q <= job_id_d;
      add_q <= add_d;
      wen_q <= wen_d;
      data_q <= data_d;
    end
  end
  assign job_ready_o = state_q == CFG_IDLE;
  assign done_o = state_q == CFG_DONE;
  assign err_o = done_o & err_q;
  assign job_id_o = job_id_q;
  assign periph_req_o = req_q;
  assign periph_add_o = add_q;
  assign periph_wen_o = wen_q;
  assign periph_be_o = 4'hF;
  assign periph_data_o = data_q;
  assign periph_id_o = '0;
  assign unused_ok = ^periph_r_id_i;
endmodule

// File: tb/tb_multi_dataflow_cfg_master.sv
// tb_multi_dataflow_cfg_master: scoreboard bench with a randomized peripheral slave
module tb_multi_dataflow_cfg_master;
  import multi_dataflow_cfg_master_pkg::*;
  localparam int PG = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic job_valid = 1'b0, job_ready, done, err, req, wen;
  job_desc_t job_desc = '0;
  logic [7:0] job_id, pid;
  logic gnt = 1'b0, r_valid = 1'b0;
  logic [31:0] add, wdata, r_data = '0;
  logic [7:0] r_id = '0;
  logic [3:0] be;
  always #5 clk = ~clk;
  multi_dataflow_cfg_master #(.ID_WIDTH(8), .REGFILE_BASE(32'h40), .POLL_GAP(PG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_desc_i(job_desc), .done_o(done), .err_o(err), .job_id_o(job_id),
    .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add), .periph_wen_o(wen),
    .periph_be_o(be), .periph_data_o(wdata), .periph_id_o(pid),
    .periph_r_valid_i(r_valid), .periph_r_data_i(r_data), .periph_r_id_i(r_id)
  );
  typedef struct {logic [31:0] add; logic wen; logic [31:0] data; int gap;} txn_t;
  typedef struct {logic err; logic [7:0] id;} done_t;
  txn_t exp_q[$];
  done_t done_q[$];
  logic [31:0] acq_rsp[$], stat_rsp[$];
  int checks = 0, errors = 0;
  int txn_idx = 0, force_txn = -1, force_wait = 0, rand_max = 0;
  int wait_left = -1;
  logic s_pend = 1'b0;
  logic [31:0] s_pdata = '0, s_d = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    gnt = 1'b0;
    r_valid = 1'b0;
    if (!rst_n) begin
      wait_left = -1;
      s_pend = 1'b0;
    end else if (s_pend) begin
      r_valid = 1'b1;
      r_data = s_pdata;
      s_pend = 1'b0;
    end else if (req) begin
      if (wait_left < 0) wait_left = (txn_idx == force_txn) ? force_wait : int'($urandom_range(0, rand_max));
      if (wait_left > 0) wait_left--;
      else begin
        gnt = 1'b1;
        wait_left = -1;
        txn_idx++;
        s_d = $urandom;
        if (wen && add == 32'h4) s_d = acq_rsp.size() > 0 ? acq_rsp.pop_front() : 32'h3;
        if (wen && add == 32'hC) s_d = stat_rsp.size() > 0 ? stat_rsp.pop_front() : 32'h0;
        if ($urandom_range(0, 1) == 1) begin
          r_valid = 1'b1;
          r_data = s_d;
        end else begin
          s_pend = 1'b1;
          s_pdata = s_d;
        end
      end
    end
  end
  logic req_prev = 1'b0, gnt_prev = 1'b0, rv_prev = 1'b0, done_prev = 1'b0, cap_wen = 1'b0;
  logic [31:0] cap_add = '0, cap_data = '0;
  int idle_cnt = 0;
  txn_t e;
  done_t dd;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      req_prev = 1'b0;
      gnt_prev = 1'b0;
      rv_prev = 1'b0;
      done_prev = 1'b0;
      idle_cnt = 0;
    end else begin
      if (req && (!req_prev || gnt_prev)) begin
        cap_add = add;
        cap_data = wdata;
        cap_wen = wen;
        if (exp_q.size() == 0) fail_now("unexpected_req", $sformatf("request to 0x%08h, expected none", add));
        else if (exp_q[0].gap >= 0) chk("gap_cycles", idle_cnt, exp_q[0].gap);
      end else if (req) begin
        chk("hold_add", add, cap_add);
        chk("hold_data", wdata, cap_data);
        chk("hold_wen", {31'd0, wen}, {31'd0, cap_wen});
      end
      if (req && gnt && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("txn_add", add, e.add);
        chk("txn_wen", {31'd0, wen}, {31'd0, e.wen});
        if (!e.wen) chk("txn_data", wdata, e.data);
      end
      if (done) begin
        chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
        if (done_q.size() == 0) fail_now("unexpected_done", "done_o pulse with no job outstanding, expected none");
        else begin
          dd = done_q.pop_front();
          chk("done_err", {31'd0, err}, {31'd0, dd.err});
          if (!dd.err) begin
            chk("done_id", {24'd0, job_id}, {24'd0, dd.id});
            chk("done_after_rvalid", {31'd0, rv_prev}, 32'd1);
          end
        end
      end else chk("err_without_done", {31'd0, err}, 32'd0);
      idle_cnt = r_valid ? 0 : (!req ? idle_cnt + 1 : idle_cnt);
      req_prev = req;
      gnt_prev = gnt;
      rv_prev = r_valid;
      done_prev = done;
    end
  end
  task automatic start_job(input job_desc_t d);
    int n = 0;
    @(negedge clk);
    while (!job_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("job_ready_idle", {31'd0, job_ready}, 32'd1);
    job_desc = d;
    job_valid = 1'b1;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    job_desc = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic wait_done();
    int n = 0;
    while ((done_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      fail_now("job_timeout", $sformatf("%0d txns, %0d done pending after 5000 cycles, expected 0", exp_q.size(), done_q.size()));
      exp_q.delete();
      done_q.delete();
      acq_rsp.delete();
      stat_rsp.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic build(input job_desc_t d, input int nfail, input logic [31:0] acq_val, input int nbusy);
    int regs[8] = '{0, 1, 2, 3, 6, 7, 16, 25};
    logic [31:0] vals[8];
    vals = '{d.in_pel_addr, d.in_size_addr, d.out_pel_addr, 32'd1, d.len, d.len, d.len, d.len};
    txn_idx = 0;
    if (d.len == 0 || d.len > CNT_LEN) begin
      done_q.push_back('{1'b1, 8'd0});
      return;
    end
    for (int i = 0; i <= nfail; i++) begin
      exp_q.push_back('{32'h4, 1'b1, 32'h0, i == 0 ? -1 : PG});
      acq_rsp.push_back(i < nfail ? 32'hFFFF_FFFF : acq_val);
    end
    for (int k = 0; k < 8; k++) exp_q.push_back('{32'h40 + 32'(4 * regs[k]), 1'b0, vals[k], 0});
    exp_q.push_back('{32'h0, 1'b0, 32'h0, 0});
    for (int p = 0; p <= nbusy; p++) begin
      exp_q.push_back('{32'hC, 1'b1, 32'h0, PG});
      stat_rsp.push_back(p < nbusy ? ($urandom | 32'h1) : 32'h0);
    end
    done_q.push_back('{1'b0, acq_val[7:0]});
  endtask
  task automatic run_job(input logic [31:0] a, b, c, len, input int nfail, input logic [31:0] acq_val, input int nbusy);
    job_desc_t d;
    d = '{a, b, c, len};
    build(d, nfail, acq_val, nbusy);
    start_job(d);
    if (len == 0 || len > CNT_LEN) begin
      @(negedge clk);
      chk("bad_len_done_early", {31'd0, done}, 32'd0);
      chk("bad_len_no_req", {31'd0, req}, 32'd0);
      @(negedge clk);
      chk("bad_len_done", {31'd0, done}, 32'd1);
      chk("bad_len_err", {31'd0, err}, 32'd1);
      chk("bad_len_no_req2", {31'd0, req}, 32'd0);
    end
    wait_done();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    job_desc_t d;
    int n;
    logic [31:0] len;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, job_ready}, 32'd1);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_be", {28'd0, be}, 32'hF);
    chk("rst_add", add, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_job_id", {24'd0, job_id}, 32'd0);
    chk("rst_pid", {24'd0, pid}, 32'd0);
    rst_n = 1'b1;
    run_job(32'h1000, 32'h2000, 32'h3000, 32'd64, 0, 32'd3, 0);
    run_job(32'h1100, 32'h2200, 32'h3300, 32'd17, 2, 32'd0, 0);
    force_txn = 3;
    force_wait = 5;
    run_job(32'hA000, 32'hB000, 32'hC000, 32'd200, 0, 32'h55, 0);
    force_txn = -1;
    run_job(32'h1, 32'h2, 32'h3, 32'd0, 0, 32'd3, 0);
    run_job(32'h1, 32'h2, 32'h3, CNT_LEN + 32'd1, 0, 32'd3, 0);
    run_job(32'h4000, 32'h5000, 32'h6000, CNT_LEN, 0, 32'h7E, 3);
    force_txn = 3;
    force_wait = 40;
    d = '{32'h7000, 32'h8000, 32'h9000, 32'd9};
    build(d, 0, 32'h12, 0);
    start_job(d);
    n = 0;
    while (!(req && add == 32'h48) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_write_addr", add, 32'h48);
    #1 rst_n = 1'b0;
    #1 chk("rst_req_async", {31'd0, req}, 32'd0);
    exp_q.delete();
    done_q.delete();
    acq_rsp.delete();
    stat_rsp.delete();
    force_txn = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, job_ready}, 32'd1);
    chk("post_rst_req", {31'd0, req}, 32'd0);
    run_job(32'hD000, 32'hE000, 32'hF000, 32'd33, 0, 32'h21, 1);
    rand_max = 2;
    for (int j = 0; j < 12; j++) begin
      n = int'($urandom_range(0, 9));
      len = n == 0 ? 32'd0 : n == 1 ? CNT_LEN + 32'd1 : n == 2 ? CNT_LEN : 32'($urandom_range(1, CNT_LEN));
      run_job($urandom, $urandom, $urandom, len, int'($urandom_range(0, 2)),
              {8'h0, 16'($urandom), 8'($urandom)}, int'($urandom_range(0, 2)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
